// File: rtl/spi_led_cmd_controller_pkg.sv
// Shared definitions for the SPI-to-WS2812B command sequencer.
package spi_led_cmd_controller_pkg;

    localparam logic [7:0] CMD_PIXELS = 8'h01;
    localparam logic [7:0] CMD_BRIGHT = 8'h02;
    localparam logic [7:0] CMD_SHOW   = 8'h03;

    localparam int PIXEL_W = 24;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        PIX_G,
        PIX_R,
        PIX_B,
        BRIGHT,
        DISCARD
    } state_t;

endpackage

// File: rtl/spi_led_cmd_controller_fb_write_slot.sv
// One-deep framebuffer write slot: holds a write until the framebuffer takes it,
// and flags any new write that arrives while one is still pending.
module fb_write_slot
    import spi_led_cmd_controller_pkg::*;
#(
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_req,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [PIXEL_W-1:0]   wr_data,
    input  logic                 fb_ready,
    output logic                 fb_we,
    output logic [ADDR_BITS-1:0] fb_addr,
    output logic [PIXEL_W-1:0]   fb_wdata,
    output logic                 err_overflow
);

    logic                 we_q, we_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [PIXEL_W-1:0]   data_q, data_d;
    logic                 ovf_q, ovf_d;

    // Next slot contents: retire on accept, load only into an empty slot.
    always_comb begin
        we_d   = we_q;
        addr_d = addr_q;
        data_d = data_q;
        ovf_d  = ovf_q;
        if (we_q && fb_ready) begin
            we_d = 1'b0;
        end
        if (wr_req) begin
            // A pixel completing while a write is still up (even one being
            // accepted this cycle) is dropped; the pending write is untouched.
            if (we_q) begin
                ovf_d = 1'b1;
            end else begin
                we_d   = 1'b1;
                addr_d = wr_addr;
                data_d = wr_data;
            end
        end
    end

    // Slot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            ovf_q  <= ovf_d;
        end
    end

    assign fb_we        = we_q;
    assign fb_addr      = addr_q;
    assign fb_wdata     = data_q;
    assign err_overflow = ovf_q;

endmodule

// File: rtl/spi_led_cmd_controller.sv
// Command sequencer: decodes SPI byte transactions into pixel writes,
// brightness updates and show pulses for the WS2812B framebuffer.
module spi_led_cmd_controller
    import spi_led_cmd_controller_pkg::*;
#(
    parameter int         NUM_LEDS           = 64,
    parameter int         ADDR_BITS          = 6,
    parameter logic [7:0] DEFAULT_BRIGHTNESS = 8'h40
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_byte,
    input  logic                 rx_done,
    input  logic                 rx_first,
    input  logic                 rx_idle,
    output logic                 fb_we,
    output logic [ADDR_BITS-1:0] fb_addr,
    output logic [PIXEL_W-1:0]   fb_wdata,
    input  logic                 fb_ready,
    output logic [7:0]           brightness,
    output logic                 show,
    output logic                 err_overflow,
    output logic                 err_range,
    output logic                 err_cmd,
    output logic                 busy
);

    state_t      state_q, state_d;
    logic [15:0] ptr_q, ptr_d;
    logic [7:0]  g_q, g_d;
    logic [7:0]  r_q, r_d;
    logic [7:0]  bright_q, bright_d;
    logic        show_q, show_d;
    logic        err_range_q, err_range_d;
    logic        err_cmd_q, err_cmd_d;

    logic                 wr_req;
    logic [PIXEL_W-1:0]   wr_data;
    logic [ADDR_BITS-1:0] wr_addr;

    assign wr_addr = ptr_q[ADDR_BITS-1:0];

    // Next state and datapath: idle wins, then a first byte resyncs, then
    // ordinary bytes advance the current transaction.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        g_d         = g_q;
        r_d         = r_q;
        bright_d    = bright_q;
        show_d      = 1'b0;
        err_range_d = err_range_q;
        err_cmd_d   = err_cmd_q;
        wr_req      = 1'b0;
        wr_data     = {g_q, r_q, rx_byte};

        if (rx_idle) begin
            state_d = IDLE;
        end else if (rx_done && rx_first) begin
            case (rx_byte)
                CMD_PIXELS: state_d = ADDR_HI;
                CMD_BRIGHT: state_d = BRIGHT;
                CMD_SHOW: begin
                    show_d  = 1'b1;
                    state_d = DISCARD;
                end
                default: begin
                    err_cmd_d = 1'b1;
                    state_d   = DISCARD;
                end
            endcase
        end else if (rx_done) begin
            case (state_q)
                IDLE:    state_d = DISCARD;
                ADDR_HI: begin
                    ptr_d[15:8] = rx_byte;
                    state_d     = ADDR_LO;
                end
                ADDR_LO: begin
                    ptr_d[7:0] = rx_byte;
                    state_d    = PIX_G;
                end
                PIX_G: begin
                    g_d     = rx_byte;
                    state_d = PIX_R;
                end
                PIX_R: begin
                    r_d     = rx_byte;
                    state_d = PIX_B;
                end
                PIX_B: begin
                    if (32'(ptr_q) < NUM_LEDS) begin
                        wr_req = 1'b1;
                    end else begin
                        err_range_d = 1'b1;
                    end
                    // Pointer advances even for out-of-range pixels; wraps at 16 bits.
                    ptr_d   = ptr_q + 16'd1;
                    state_d = PIX_G;
                end
                BRIGHT: begin
                    bright_d = rx_byte;
                    state_d  = DISCARD;
                end
                default: state_d = DISCARD;
            endcase
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            g_q         <= '0;
            r_q         <= '0;
            bright_q    <= DEFAULT_BRIGHTNESS;
            show_q      <= 1'b0;
            err_range_q <= 1'b0;
            err_cmd_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            g_q         <= g_d;
            r_q         <= r_d;
            bright_q    <= bright_d;
            show_q      <= show_d;
            err_range_q <= err_range_d;
            err_cmd_q   <= err_cmd_d;
        end
    end

    fb_write_slot #(
        .ADDR_BITS (ADDR_BITS)
    ) u_slot (
        .clk          (clk),
        .reset        (reset),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .fb_ready     (fb_ready),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_wdata     (fb_wdata),
        .err_overflow (err_overflow)
    );

    assign brightness = bright_q;
    assign show       = show_q;
    assign err_range  = err_range_q;
    assign err_cmd    = err_cmd_q;
    assign busy       = (state_q != IDLE) || fb_we;

endmodule

// File: tb/tb_spi_led_cmd_controller.sv
// Self-checking bench: directed scenarios plus randomized transactions scored
// against a transaction-level model of expected writes, brightness and shows.
module tb_spi_led_cmd_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_done, rx_first, rx_idle;
    logic        fb_we;
    logic [5:0]  fb_addr;
    logic [23:0] fb_wdata;
    logic        fb_ready;
    logic [7:0]  brightness;
    logic        show;
    logic        err_overflow, err_range, err_cmd, busy;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [29:0] acc_q[$];
    int          show_cnt = 0;

    always #5 clk = ~clk;

    spi_led_cmd_controller #(
        .NUM_LEDS (64), .ADDR_BITS (6), .DEFAULT_BRIGHTNESS (8'h40)
    ) dut (
        .clk (clk), .reset (reset), .rx_byte (rx_byte), .rx_done (rx_done),
        .rx_first (rx_first), .rx_idle (rx_idle), .fb_we (fb_we),
        .fb_addr (fb_addr), .fb_wdata (fb_wdata), .fb_ready (fb_ready),
        .brightness (brightness), .show (show), .err_overflow (err_overflow),
        .err_range (err_range), .err_cmd (err_cmd), .busy (busy)
    );

    // Observe accepted writes and show pulses mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (fb_we && fb_ready) acc_q.push_back({fb_addr, fb_wdata});
        if (show) show_cnt++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic first, input int gap);
        @(posedge clk); #1;
        rx_byte = b; rx_done = 1'b1; rx_first = first;
        @(posedge clk); #1;
        rx_done = 1'b0; rx_first = 1'b0;
        if (gap > 0) wait_cycles(gap);
    endtask

    task automatic send_idle();
        @(posedge clk); #1;
        rx_idle = 1'b1;
        @(posedge clk); #1;
        rx_idle = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++; if (fb_we !== 1'b0) $display("FAIL reset_fb_we: got %b want 0", fb_we); else pass_cnt++;
        chk_cnt++; if (fb_addr !== 6'd0) $display("FAIL reset_fb_addr: got %h want 0", fb_addr); else pass_cnt++;
        chk_cnt++; if (fb_wdata !== 24'd0) $display("FAIL reset_fb_wdata: got %h want 0", fb_wdata); else pass_cnt++;
        chk_cnt++; if (brightness !== 8'h40) $display("FAIL reset_brightness: got %h want 40", brightness); else pass_cnt++;
        chk_cnt++; if (show !== 1'b0) $display("FAIL reset_show: got %b want 0", show); else pass_cnt++;
        chk_cnt++; if ({err_overflow, err_range, err_cmd} !== 3'b000)
            $display("FAIL reset_errs: got %b want 000", {err_overflow, err_range, err_cmd}); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_pixel_write();
        fb_ready = 1'b1;
        acc_q.delete();
        send_byte(8'h01, 1'b1, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h05, 1'b0, 0);
        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h22, 1'b0, 0);
        send_byte(8'h33, 1'b0, 0);
        chk_cnt++; if (fb_we !== 1'b1 || fb_addr !== 6'd5)
            $display("FAIL pix_we_latency: got we=%b addr=%h want we=1 addr=05", fb_we, fb_addr); else pass_cnt++;
        wait_cycles(3);
        chk_cnt++; if (acc_q.size() != 1) $display("FAIL pix_accepts: got %0d want 1", acc_q.size()); else pass_cnt++;
        if (acc_q.size() >= 1) begin
            chk_cnt++; if (acc_q[0] !== {6'd5, 24'h112233})
                $display("FAIL pix_data: got %h want %h", acc_q[0], {6'd5, 24'h112233}); else pass_cnt++;
        end
        chk_cnt++; if ({err_overflow, err_range, err_cmd} !== 3'b000)
            $display("FAIL pix_errs: got %b want 000", {err_overflow, err_range, err_cmd}); else pass_cnt++;
        send_idle();
    endtask

    task automatic test_backpressure();
        fb_ready = 1'b0;
        acc_q.delete();
        send_byte(8'h01, 1'b1, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'hA1, 1'b0, 0); send_byte(8'hA2, 1'b0, 0); send_byte(8'hA3, 1'b0, 0);
        send_byte(8'hB1, 1'b0, 0); send_byte(8'hB2, 1'b0, 0); send_byte(8'hB3, 1'b0, 0);
        chk_cnt++; if (fb_we !== 1'b1 || fb_addr !== 6'd0 || fb_wdata !== 24'hA1A2A3)
            $display("FAIL bp_held: got we=%b addr=%h data=%h want 1/00/a1a2a3", fb_we, fb_addr, fb_wdata); else pass_cnt++;
        chk_cnt++; if (err_overflow !== 1'b1) $display("FAIL bp_overflow: got %b want 1", err_overflow); else pass_cnt++;
        chk_cnt++; if (acc_q.size() != 0) $display("FAIL bp_no_accept: got %0d want 0", acc_q.size()); else pass_cnt++;
        fb_ready = 1'b1;
        wait_cycles(4);
        chk_cnt++; if (acc_q.size() != 1 || acc_q[0] !== {6'd0, 24'hA1A2A3})
            $display("FAIL bp_release: got n=%0d want one accept of 00/a1a2a3", acc_q.size()); else pass_cnt++;
        send_idle();
    endtask

    task automatic test_range();
        fb_ready = 1'b1;
        acc_q.delete();
        send_byte(8'h01, 1'b1, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h3F, 1'b0, 0);
        send_byte(8'h01, 1'b0, 0); send_byte(8'h02, 1'b0, 0); send_byte(8'h03, 1'b0, 0);
        chk_cnt++; if (err_range !== 1'b0) $display("FAIL range_last_ok: got %b want 0", err_range); else pass_cnt++;
        send_byte(8'h04, 1'b0, 0); send_byte(8'h05, 1'b0, 0); send_byte(8'h06, 1'b0, 0);
        chk_cnt++; if (fb_we !== 1'b0) $display("FAIL range_no_we: got %b want 0", fb_we); else pass_cnt++;
        chk_cnt++; if (err_range !== 1'b1) $display("FAIL range_err: got %b want 1", err_range); else pass_cnt++;
        wait_cycles(2);
        chk_cnt++; if (acc_q.size() != 1 || acc_q[0] !== {6'd63, 24'h010203})
            $display("FAIL range_accepts: got n=%0d want one accept of 3f/010203", acc_q.size()); else pass_cnt++;
        send_idle();
    endtask

    task automatic test_bright_show();
        int base;
        send_byte(8'h02, 1'b1, 0);
        send_byte(8'h80, 1'b0, 0);
        chk_cnt++; if (brightness !== 8'h80) $display("FAIL bright_val: got %h want 80", brightness); else pass_cnt++;
        base = show_cnt;
        send_byte(8'h03, 1'b1, 0);
        chk_cnt++; if (show !== 1'b1) $display("FAIL show_latency: got %b want 1", show); else pass_cnt++;
        wait_cycles(3);
        chk_cnt++; if (show_cnt - base != 1) $display("FAIL show_pulses: got %0d want 1", show_cnt - base); else pass_cnt++;
        send_idle();
    endtask

    task automatic test_abort();
        fb_ready = 1'b1;
        acc_q.delete();
        send_byte(8'h01, 1'b1, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h02, 1'b0, 0);
        send_byte(8'hAA, 1'b0, 0);
        send_idle();
        chk_cnt++; if (busy !== 1'b0 || fb_we !== 1'b0)
            $display("FAIL abort_idle: got busy=%b we=%b want 0/0", busy, fb_we); else pass_cnt++;
        send_byte(8'h01, 1'b1, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h02, 1'b0, 0);
        send_byte(8'hAA, 1'b0, 0); send_byte(8'hBB, 1'b0, 0); send_byte(8'hCC, 1'b0, 0);
        wait_cycles(3);
        chk_cnt++; if (acc_q.size() != 1 || acc_q[0] !== {6'd2, 24'hAABBCC})
            $display("FAIL resync_write: got n=%0d want one accept of 02/aabbcc", acc_q.size()); else pass_cnt++;
        send_byte(8'h7F, 1'b1, 0);
        chk_cnt++; if (err_cmd !== 1'b1) $display("FAIL bad_cmd: got %b want 1", err_cmd); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL bad_cmd_busy: got %b want 1", busy); else pass_cnt++;
        send_idle();
    endtask

    task automatic test_reset_pending();
        fb_ready = 1'b0;
        send_byte(8'h01, 1'b1, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h07, 1'b0, 0);
        send_byte(8'h12, 1'b0, 0); send_byte(8'h34, 1'b0, 0); send_byte(8'h56, 1'b0, 0);
        chk_cnt++; if (fb_we !== 1'b1) $display("FAIL rstp_pending: got %b want 1", fb_we); else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_cnt++; if (fb_we !== 1'b0) $display("FAIL rstp_we: got %b want 0", fb_we); else pass_cnt++;
        chk_cnt++; if (brightness !== 8'h40) $display("FAIL rstp_bright: got %h want 40", brightness); else pass_cnt++;
        chk_cnt++; if ({err_overflow, err_range, err_cmd} !== 3'b000 || busy !== 1'b0)
            $display("FAIL rstp_errs: got errs=%b busy=%b want 000/0", {err_overflow, err_range, err_cmd}, busy); else pass_cnt++;
        fb_ready = 1'b1;
    endtask

    // Random transactions; model predicts writes per whole pixel from the
    // start address, ignoring any trailing partial pixel.
    task automatic test_random();
        logic [29:0] exp_q[$];
        logic [7:0]  exp_bright = 8'h40;
        logic        exp_range  = 1'b0;
        int          exp_shows  = 0;
        int          base;
        logic [15:0] addr, a;
        logic [7:0]  g, r, b;
        int          npix, kind;
        fb_ready = 1'b1;
        acc_q.delete();
        base = show_cnt;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                case ($urandom_range(0, 3))
                    0: addr = 16'($urandom_range(0, 63));
                    1: addr = 16'($urandom_range(58, 70));
                    2: addr = 16'($urandom);
                    default: addr = 16'hFFFE;
                endcase
                npix = $urandom_range(1, 4);
                send_byte(8'h01, 1'b1, $urandom_range(0, 1));
                send_byte(addr[15:8], 1'b0, $urandom_range(0, 1));
                send_byte(addr[7:0], 1'b0, $urandom_range(0, 1));
                for (int i = 0; i < npix; i++) begin
                    a = addr + 16'(i);
                    g = 8'($urandom); r = 8'($urandom); b = 8'($urandom);
                    send_byte(g, 1'b0, $urandom_range(0, 1));
                    send_byte(r, 1'b0, $urandom_range(0, 1));
                    send_byte(b, 1'b0, $urandom_range(0, 1));
                    if (a < 16'd64) exp_q.push_back({a[5:0], g, r, b});
                    else exp_range = 1'b1;
                end
                if ($urandom_range(0, 3) == 0) begin
                    for (int k = 0; k < int'($urandom_range(1, 2)); k++) send_byte(8'($urandom), 1'b0, 0);
                end
                send_idle();
                for (int k = 0; k < int'($urandom_range(0, 2)); k++) send_byte(8'($urandom), 1'b0, 0);
            end else if (kind < 8) begin
                exp_bright = 8'($urandom);
                send_byte(8'h02, 1'b1, $urandom_range(0, 1));
                send_byte(exp_bright, 1'b0, 0);
                if ($urandom_range(0, 1) == 1) send_idle();
            end else begin
                send_byte(8'h03, 1'b1, 0);
                exp_shows++;
                if ($urandom_range(0, 1) == 1) send_idle();
            end
        end
        wait_cycles(5);
        chk_cnt++; if (acc_q.size() != exp_q.size())
            $display("FAIL rnd_write_count: got %0d want %0d", acc_q.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
            chk_cnt++; if (acc_q[i] !== exp_q[i])
                $display("FAIL rnd_write[%0d]: got %h want %h", i, acc_q[i], exp_q[i]); else pass_cnt++;
        end
        chk_cnt++; if (brightness !== exp_bright) $display("FAIL rnd_bright: got %h want %h", brightness, exp_bright); else pass_cnt++;
        chk_cnt++; if (show_cnt - base != exp_shows) $display("FAIL rnd_shows: got %0d want %0d", show_cnt - base, exp_shows); else pass_cnt++;
        chk_cnt++; if (err_range !== exp_range) $display("FAIL rnd_range: got %b want %b", err_range, exp_range); else pass_cnt++;
        chk_cnt++; if (err_overflow !== 1'b0 || err_cmd !== 1'b0)
            $display("FAIL rnd_other_errs: got ovf=%b cmd=%b want 0/0", err_overflow, err_cmd); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; rx_byte = 8'h00; rx_done = 1'b0; rx_first = 1'b0;
        rx_idle = 1'b0; fb_ready = 1'b1;
        test_reset();
        test_pixel_write();
        test_backpressure();
        test_range();
        test_bright_show();
        test_abort();
        test_reset_pending();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
